ifetch_buffer: RTL

//  Parametrised instruction-fetch front end between the core F stage and a synchronous instruction SRAM (1-cycle read latency).

---
 rtl/ifetch_buffer_pkg.sv | 14 +
 rtl/ifetch_fifo.sv | 69 ++++++
 rtl/ifetch_buffer.sv | 118 +++++++++++
 3 files changed

// File: rtl/ifetch_buffer_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_buffer_pkg
//   Shared constants for the instruction-fetch front end.
//   IFB_RESET_PC : default first fetch address after reset
//   PC_STEP      : byte distance between consecutive instructions
//   NOP_INSTR    : canonical no-op encoding (addi x0,x0,0) for this codebase
// ----------------------------------------------------------------------------
package ifetch_buffer_pkg;

    localparam logic [31:0] IFB_RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_STEP      = 4;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

endpackage : ifetch_buffer_pkg

// File: rtl/ifetch_fifo.sv
// ----------------------------------------------------------------------------
// ifetch_fifo
//   Synchronous first-word-fall-through FIFO holding {instruction, pc} pairs.
//   The head entry is visible on head_data whenever count != 0.
//   Ports:
//     clk, rst    clock (rising edge) and asynchronous active-low reset
//     flush       drop every entry; wins over push and pop in the same cycle
//     push        write push_data at the tail
//     push_data   entry to write
//     pop         retire the head entry
//     head_data   entry at the head (undefined when empty)
//     count       number of occupied entries, 0..DEPTH
// ----------------------------------------------------------------------------
module ifetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // NOTE: the storage array has no reset; occupancy is tracked entirely by
    // count and the pointers, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so they wrap
    // mod DEPTH on their own.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = storage[rd_ptr];

endmodule : ifetch_fifo

// File: rtl/ifetch_buffer.sv
// ----------------------------------------------------------------------------
// ifetch_buffer
//   Instruction-fetch front end between the core F stage and a synchronous
//   instruction SRAM with one cycle of read latency. Keeps fetching into a
//   DEPTH-entry buffer while the core stalls, and flushes on redirect.
//   Ports:
//     clk, rst        clock (rising edge), asynchronous active-low reset
//     redirect_valid  flush the buffer and refetch from redirect_pc
//     redirect_pc     new fetch byte PC; bits [1:0] ignored
//     instr_ready     core accepts the head instruction this cycle
//     instr_valid     instr / instr_pc hold a valid instruction
//     instr           instruction at the buffer head (0 when empty)
//     instr_pc        byte PC of instr (0 when empty)
//     mem_en          SRAM read enable
//     mem_addr        SRAM word address
//     mem_rdata       SRAM read data, valid the cycle after mem_en
//     buf_count       occupied buffer entries
// ----------------------------------------------------------------------------
module ifetch_buffer
    import ifetch_buffer_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          PC_WIDTH   = 32,
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter int unsigned          DEPTH      = 2,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = PC_WIDTH'(IFB_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [PC_WIDTH-1:0]      redirect_pc,
    input  logic                     instr_ready,
    output logic                     instr_valid,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [PC_WIDTH-1:0]      instr_pc,
    output logic                     mem_en,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [$clog2(DEPTH):0]   buf_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PC_WIDTH-1:0] STEP    = PC_WIDTH'(PC_STEP);
    localparam logic [CNT_W:0]      DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [PC_WIDTH-1:0]            fetch_pc;
    logic [PC_WIDTH-1:0]            issued_pc;
    logic                           inflight;

    logic [PC_WIDTH-1:0]            redirect_base;
    logic                           pop;
    logic                           push_resp;
    logic                           credit_ok;
    logic [CNT_W:0]                 occupancy;
    logic [DATA_WIDTH+PC_WIDTH-1:0] head_entry;
    logic                           unused_pc_bits;

    // Instructions are word aligned; the low PC bits carry no information.
    assign unused_pc_bits = ^redirect_pc[1:0];
    assign redirect_base  = {redirect_pc[PC_WIDTH-1:2], 2'b00};

    // A redirect cycle never retires the head: the head belongs to the old path.
    assign pop = instr_valid & instr_ready & ~redirect_valid;

    // Credit check: buffered entries plus the read in flight, minus what leaves
    // this cycle, must stay below DEPTH so the next response always has a slot.
    // Written as occupancy < DEPTH + pop to avoid an unsigned underflow.
    assign occupancy = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight};
    assign credit_ok = occupancy < (DEPTH_C + {{CNT_W{1'b0}}, pop});

    // A redirect fetch bypasses the credit check because the flush frees the
    // whole buffer at the same edge. Reset gates the enable so the SRAM is idle
    // while rst is held low.
    assign mem_en   = rst & (redirect_valid | credit_ok);
    assign mem_addr = redirect_valid ? redirect_pc[ADDR_WIDTH+1:2]
                                     : fetch_pc[ADDR_WIDTH+1:2];

    // The response to a read issued before a redirect is dropped: the flush
    // and the redirect fetch both happen at this edge.
    assign push_resp = inflight & ~redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc  <= redirect_base + STEP;
            issued_pc <= redirect_base;
            inflight  <= 1'b1;
        end else if (credit_ok) begin
            fetch_pc  <= fetch_pc + STEP;
            issued_pc <= fetch_pc;
            inflight  <= 1'b1;
        end else begin
            inflight  <= 1'b0;
        end
    end

    ifetch_fifo #(
        .WIDTH (DATA_WIDTH + PC_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push_resp),
        .push_data ({mem_rdata, issued_pc}),
        .pop       (pop),
        .head_data (head_entry),
        .count     (buf_count)
    );

    assign instr_valid = (buf_count != '0);
    assign instr       = instr_valid ? head_entry[DATA_WIDTH+PC_WIDTH-1:PC_WIDTH] : '0;
    assign instr_pc    = instr_valid ? head_entry[PC_WIDTH-1:0] : '0;

endmodule : ifetch_buffer
